mem_bus_decoder: RTL

- Sits between the PicoRV32 native memory port and the on-chip RAM slave.
- Decodes each CPU request by mem_addr[31:20]. Regions:
  - RAM region: forwarded through a registered handshake.
  - MMIO regions: served locally (LEDs, switches, cycle timer, error status).
  - Unmapped region: answered with an error word.
- Replaces ad-hoc LED decode inside the RAM. Adds timeout protection for a hung slave.

---
 rtl/mem_bus_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - PicoRV32 memory bus decoder: RAM forwarding, LED/switch/timer MMIO, error and optional timeout (BUS_TIMEOUT_EN)
module mem_bus_decoder #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [11:0] RAM_REGION     = 12'h000,
  parameter logic [11:0] LED_REGION     = 12'hFF2,
  parameter logic [11:0] SW_REGION      = 12'hFF3,
  parameter logic [11:0] TMR_REGION     = 12'hFF4,
  parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  output logic        cpu_mem_ready,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic [31:0] cpu_mem_rdata,
  output logic        ram_mem_valid,
  output logic        ram_mem_instr,
  input  logic        ram_mem_ready,
  output logic [31:0] ram_mem_addr,
  output logic [31:0] ram_mem_wdata,
  output logic [3:0]  ram_mem_wstrb,
  input  logic [31:0] ram_mem_rdata,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        ram_valid_q, ram_valid_d;
  logic        ram_instr_q, ram_instr_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  ram_wstrb_q, ram_wstrb_d;
  logic [9:0]  led_q, led_d;
  logic [9:0]  sw_meta_q, sw_meta_d;
  logic [9:0]  sw_sync_q, sw_sync_d;
  logic [31:0] tmr_q, tmr_d;
  logic        bus_error_q, bus_error_d;
  logic        err_set, err_clr;
  logic [11:0] region;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  to_cnt_q, to_cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign region = cpu_mem_addr[31:20];

  // Next-state: request decode, MMIO access, RAM handshake and timeout
  always_comb begin
    state_d     = state_q;
    cpu_ready_d = cpu_ready_q;
    cpu_rdata_d = cpu_rdata_q;
    ram_valid_d = ram_valid_q;
    ram_instr_d = ram_instr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wstrb_d = ram_wstrb_q;
    led_d       = led_q;
    sw_meta_d   = SW;
    sw_sync_d   = sw_meta_q;
    tmr_d       = tmr_q + 32'd1;
    err_set     = 1'b0;
    err_clr     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_mem_valid && !cpu_ready_q) begin
          if (region == RAM_REGION) begin
            ram_valid_d = 1'b1;
            ram_instr_d = cpu_mem_instr;
            ram_addr_d  = cpu_mem_addr;
            ram_wdata_d = cpu_mem_wdata;
            ram_wstrb_d = cpu_mem_wstrb;
            state_d     = RAM_WAIT;
          end else begin
            cpu_ready_d = 1'b1;
            state_d     = RESP;
            if (region == LED_REGION) begin
              cpu_rdata_d = {22'b0, led_q};
              if (cpu_mem_wstrb[0]) led_d[7:0] = cpu_mem_wdata[7:0];
              if (cpu_mem_wstrb[1]) led_d[9:8] = cpu_mem_wdata[9:8];
            end else if (region == SW_REGION) begin
              cpu_rdata_d = {22'b0, sw_sync_q};
            end else if (region == TMR_REGION) begin
              case (cpu_mem_addr[3:2])
                2'd0: begin
                  cpu_rdata_d = tmr_q;
                  if (cpu_mem_wstrb == 4'hF) tmr_d = cpu_mem_wdata;
                end
                2'd1: begin
                  cpu_rdata_d = {31'b0, bus_error_q};
                  if ((cpu_mem_wstrb != 4'h0) && cpu_mem_wdata[0]) err_clr = 1'b1;
                end
                default: cpu_rdata_d = 32'h0;
              endcase
            end else begin
              cpu_rdata_d = ERR_WORD;
              err_set     = 1'b1;
            end
          end
        end
      end
      RAM_WAIT: begin
        if (ram_mem_ready) begin
          cpu_rdata_d = ram_mem_rdata;
          cpu_ready_d = 1'b1;
          ram_valid_d = 1'b0;
          state_d     = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          cpu_rdata_d = ERR_WORD;
          cpu_ready_d = 1'b1;
          ram_valid_d = 1'b0;
          err_set     = 1'b1;
          state_d     = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        cpu_ready_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_cnt_d    = 8'd0;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A set in the same cycle as a clear keeps the error visible
    bus_error_d = err_set ? 1'b1 : (err_clr ? 1'b0 : bus_error_q);
  end

  // State and register update with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'h0;
      ram_valid_q <= 1'b0;
      ram_instr_q <= 1'b0;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      ram_wstrb_q <= 4'h0;
      led_q       <= 10'h0;
      sw_meta_q   <= 10'h0;
      sw_sync_q   <= 10'h0;
      tmr_q       <= 32'h0;
      bus_error_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_valid_q <= ram_valid_d;
      ram_instr_q <= ram_instr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      tmr_q       <= tmr_d;
      bus_error_q <= bus_error_d;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign cpu_mem_ready = cpu_ready_q;
  assign cpu_mem_rdata = cpu_rdata_q;
  assign ram_mem_valid = ram_valid_q;
  assign ram_mem_instr = ram_instr_q;
  assign ram_mem_addr  = ram_addr_q;
  assign ram_mem_wdata = ram_wdata_q;
  assign ram_mem_wstrb = ram_wstrb_q;
  assign LEDR          = led_q;
  assign bus_error     = bus_error_q;

endmodule
